// File: rtl/flow_ctrl_multi.sv
// flow_ctrl_multi
// Multi-channel flow-control FSM bank. Each of NCH channels follows its own
// FIFO status flags and reports continue/pause/error/idle. The block also
// gives the upstream source aggregate status and a saturating count of
// ERROR entries.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   iniciar        start command shared by all channels (INIT -> IDLE)
//   full           per-channel FIFO full
//   almost_full    per-channel almost-full
//   almost_empty   per-channel almost-empty
//   empty          per-channel empty
//   clear_err      per-channel error acknowledge (only acted on in ERROR)
//   clr_count      synchronous clear of err_count
//   continuar      channel in CONTINUE
//   pausa          channel in PAUSE
//   error_full     channel in ERROR or RECOVER
//   idle           channel in IDLE
//   pausa_any      OR of pausa
//   error_any      OR of error_full
//   all_idle       AND of idle
//   err_count      saturating count of ERROR entries
module flow_ctrl_multi #(
  parameter int NCH          = 4,
  parameter int ERR_HOLD     = 2,
  parameter int AUTO_RECOVER = 1,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iniciar,
  input  logic [NCH-1:0]   full,
  input  logic [NCH-1:0]   almost_full,
  input  logic [NCH-1:0]   almost_empty,
  input  logic [NCH-1:0]   empty,
  input  logic [NCH-1:0]   clear_err,
  input  logic             clr_count,
  output logic [NCH-1:0]   continuar,
  output logic [NCH-1:0]   pausa,
  output logic [NCH-1:0]   error_full,
  output logic [NCH-1:0]   idle,
  output logic             pausa_any,
  output logic             error_any,
  output logic             all_idle,
  output logic [CNT_W-1:0] err_count
);

  localparam int HOLD_W = $clog2(ERR_HOLD + 1);
  localparam int SUM_W  = $clog2(NCH + 1);
  // Wide enough that the running count plus a full burst of entries
  // cannot overflow before the saturation compare.
  localparam int EXT_W  = ((CNT_W > SUM_W) ? CNT_W : SUM_W) + 1;

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_IDLE     = 3'd1,
    S_ACTIVE   = 3'd2,
    S_PAUSE    = 3'd3,
    S_CONTINUE = 3'd4,
    S_ERROR    = 3'd5,
    S_RECOVER  = 3'd6
  } state_t;

  logic [NCH-1:0] enter_err;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    state_t            state_reg;
    logic [HOLD_W-1:0] hold_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_reg <= S_INIT;
        hold_reg  <= '0;
      end else begin
        case (state_reg)
          S_INIT: begin
            if (iniciar) state_reg <= S_IDLE;
          end
          S_IDLE: begin
            if (full[gi]) begin
              state_reg <= S_ERROR;
              hold_reg  <= HOLD_W'(1);
            end else if (!empty[gi]) begin
              state_reg <= S_ACTIVE;
            end
          end
          S_ACTIVE: begin
            if (full[gi]) begin
              state_reg <= S_ERROR;
              hold_reg  <= HOLD_W'(1);
            end else if (almost_full[gi]) begin
              state_reg <= S_PAUSE;
            end else if (empty[gi]) begin
              state_reg <= S_IDLE;
            end else if (almost_empty[gi]) begin
              state_reg <= S_CONTINUE;
            end
          end
          S_PAUSE: begin
            if (full[gi]) begin
              state_reg <= S_ERROR;
              hold_reg  <= HOLD_W'(1);
            end else if (!almost_full[gi]) begin
              state_reg <= S_ACTIVE;
            end
          end
          S_CONTINUE: begin
            if (full[gi]) begin
              state_reg <= S_ERROR;
              hold_reg  <= HOLD_W'(1);
            end else begin
              state_reg <= S_ACTIVE;
            end
          end
          S_ERROR: begin
            // FIFO flags are deliberately ignored while in ERROR.
            if (clear_err[gi]) begin
              state_reg <= S_RECOVER;
              hold_reg  <= '0;
            end else if ((AUTO_RECOVER != 0) && (hold_reg == HOLD_W'(ERR_HOLD))) begin
              state_reg <= S_RECOVER;
              hold_reg  <= '0;
            end else if (hold_reg != HOLD_W'(ERR_HOLD)) begin
              // Stop at ERR_HOLD so a non-recovering channel never wraps.
              hold_reg <= hold_reg + HOLD_W'(1);
            end
          end
          S_RECOVER: begin
            state_reg <= S_IDLE;
          end
          default: begin
            state_reg <= S_INIT;
            hold_reg  <= '0;
          end
        endcase
      end
    end

    // A channel enters ERROR exactly when full is seen in one of the
    // flag-driven states; mirrors the transitions above.
    assign enter_err[gi] = full[gi] &&
                           ((state_reg == S_IDLE)   || (state_reg == S_ACTIVE) ||
                            (state_reg == S_PAUSE)  || (state_reg == S_CONTINUE));

    assign continuar[gi]  = (state_reg == S_CONTINUE);
    assign pausa[gi]      = (state_reg == S_PAUSE);
    assign error_full[gi] = (state_reg == S_ERROR) || (state_reg == S_RECOVER);
    assign idle[gi]       = (state_reg == S_IDLE);
  end

  assign pausa_any = |pausa;
  assign error_any = |error_full;
  assign all_idle  = &idle;

  // Error-entry counter
  logic [SUM_W-1:0] entry_sum;
  logic [EXT_W-1:0] sum_ext;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] count_reg;

  always_comb begin
    entry_sum = '0;
    for (int i = 0; i < NCH; i++) begin
      entry_sum = entry_sum + SUM_W'(enter_err[i]);
    end
    sum_ext = EXT_W'(count_reg) + EXT_W'(entry_sum);
    if (clr_count) begin
      count_next = '0;
    end else if (sum_ext > {{(EXT_W - CNT_W){1'b0}}, {CNT_W{1'b1}}}) begin
      count_next = '1;
    end else begin
      count_next = sum_ext[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign err_count = count_reg;

endmodule
